// File: rtl/mem_resp_if.sv
// Request/response bundle between the core's memory port and mem_responder.
// The byte-enable lane exists only when MEM_RESP_BYTE_EN_EN is defined.
interface mem_resp_if #(
  parameter int ADDR_W = 9
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
`ifdef MEM_RESP_BYTE_EN_EN
  logic [3:0]        be;
`endif
  logic [31:0]       rdata;
  logic              ready;
  logic              busy;
  logic              err;

`ifdef MEM_RESP_BYTE_EN_EN
  modport master (output mem_read, mem_write, addr, wdata, be,
                  input  rdata, ready, busy, err);
  modport slave  (input  mem_read, mem_write, addr, wdata, be,
                  output rdata, ready, busy, err);
`else
  modport master (output mem_read, mem_write, addr, wdata,
                  input  rdata, ready, busy, err);
  modport slave  (input  mem_read, mem_write, addr, wdata,
                  output rdata, ready, busy, err);
`endif
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with programmable wait states and a one-cycle ready pulse.
// Optional byte-lane writes are enabled by defining MEM_RESP_BYTE_EN_EN.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  mem_resp_if.slave  bus
);
  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT     = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_rd, r_wr, r_oob, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [DEPTH];
`ifdef MEM_RESP_BYTE_EN_EN
  logic [3:0]        r_be;
`endif

  logic             w_req, w_oob_in, w_we;
  logic [IDX_W-1:0] w_idx;

  assign w_req    = bus.mem_read | bus.mem_write;
  assign w_oob_in = {1'b0, bus.addr} >= LIMIT;
  assign w_idx    = r_addr[IDX_W-1:0];
  // Reset in ACCESS must suppress the write, so rst gates the enable directly.
  assign w_we     = (r_state == S_ACCESS) && r_wr && !r_rd && !r_oob && !i_rst;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_req) w_state_nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (r_cnt <= 4'd1) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_oob   <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef MEM_RESP_BYTE_EN_EN
      r_be    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (w_req) begin
          r_rd    <= bus.mem_read;
          r_wr    <= bus.mem_write;
          r_addr  <= bus.addr;
          r_wdata <= bus.wdata;
          r_oob   <= w_oob_in;
          r_err   <= (bus.mem_read & bus.mem_write) | w_oob_in;
          r_cnt   <= WAIT_INIT;
`ifdef MEM_RESP_BYTE_EN_EN
          r_be    <= bus.be;
`endif
        end
        S_WAIT:   r_cnt <= r_cnt - 4'd1;
        S_ACCESS: if (r_rd && !r_wr) r_rdata <= r_oob ? 32'd0 : r_mem[w_idx];
        default:  ;
      endcase
    end
  end

  // Array has no reset so it can map onto a plain RAM.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
`ifdef MEM_RESP_BYTE_EN_EN
      for (int b = 0; b < 4; b++)
        if (r_be[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
`else
      r_mem[w_idx] <= r_wdata;
`endif
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ready = (r_state == S_DONE);
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.err   = (r_state == S_DONE) && r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: default, zero-wait and DEPTH=256 instances side by side.
`timescale 1ns/1ps
module tb_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_q [3];
  logic        rd_q  [3];
  logic        wr_q  [3];
  logic [8:0]  addr_q[3];
  logic [31:0] wd_q  [3];
  logic [3:0]  be_q  [3];
  logic [31:0] rdata_o[3];
  logic        rdy_o [3];
  logic        busy_o[3];
  logic        err_o [3];

  mem_resp_if #(.ADDR_W(9)) bus0 ();
  mem_resp_if #(.ADDR_W(9)) bus1 ();
  mem_resp_if #(.ADDR_W(9)) bus2 ();

  assign bus0.mem_read = rd_q[0]; assign bus0.mem_write = wr_q[0];
  assign bus0.addr = addr_q[0];   assign bus0.wdata = wd_q[0];
  assign bus1.mem_read = rd_q[1]; assign bus1.mem_write = wr_q[1];
  assign bus1.addr = addr_q[1];   assign bus1.wdata = wd_q[1];
  assign bus2.mem_read = rd_q[2]; assign bus2.mem_write = wr_q[2];
  assign bus2.addr = addr_q[2];   assign bus2.wdata = wd_q[2];
`ifdef MEM_RESP_BYTE_EN_EN
  assign bus0.be = be_q[0]; assign bus1.be = be_q[1]; assign bus2.be = be_q[2];
`endif
  assign rdata_o[0] = bus0.rdata; assign rdy_o[0] = bus0.ready;
  assign busy_o[0] = bus0.busy;   assign err_o[0] = bus0.err;
  assign rdata_o[1] = bus1.rdata; assign rdy_o[1] = bus1.ready;
  assign busy_o[1] = bus1.busy;   assign err_o[1] = bus1.err;
  assign rdata_o[2] = bus2.rdata; assign rdy_o[2] = bus2.ready;
  assign busy_o[2] = bus2.busy;   assign err_o[2] = bus2.err;

  mem_responder #(.ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(2)) u_dut0 (.i_clk(clk), .i_rst(rst_q[0]), .bus(bus0));
  mem_responder #(.ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(0)) u_dut1 (.i_clk(clk), .i_rst(rst_q[1]), .bus(bus1));
  mem_responder #(.ADDR_W(9), .DEPTH(256), .WAIT_CYCLES(2)) u_dut2 (.i_clk(clk), .i_rst(rst_q[2]), .bus(bus2));

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lat_exp(input int k);
    return (k == 1) ? 2 : 4;
  endfunction

  // One complete transaction: push expectation, hold request until ready, drop, check idle.
  task automatic do_txn(input int k, input logic rd, input logic wr, input logic [8:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int   n, nb;
    logic done;
    e.rdata = exp_rd; e.err = exp_err;
    sb.push_back(e);
    @(negedge clk);
    rd_q[k] = rd; wr_q[k] = wr; addr_q[k] = a; wd_q[k] = d; be_q[k] = b;
    n = 0; nb = 0; done = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (busy_o[k]) nb++;
      if (rdy_o[k]) done = 1'b1;
    end
    rd_q[k] = 1'b0; wr_q[k] = 1'b0;
    chk("latency", 32'(n), 32'(lat_exp(k)));
    chk("busy_cycles", 32'(nb), 32'(lat_exp(k)));
    e = sb.pop_front();
    chk("err", {31'd0, err_o[k]}, {31'd0, e.err});
    chk("rdata", rdata_o[k], e.rdata);
    @(negedge clk);
    chk("ready_clr", {31'd0, rdy_o[k]}, 32'd0);
    chk("busy_clr", {31'd0, busy_o[k]}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int   n, np, t1, t2;
    for (int k = 0; k < 3; k++) begin
      rst_q[k] = 1'b1; rd_q[k] = 1'b0; wr_q[k] = 1'b0;
      addr_q[k] = '0; wd_q[k] = '0; be_q[k] = 4'hF;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata_o[0], 32'd0);
    chk("rst_ready", {31'd0, rdy_o[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy_o[0]}, 32'd0);
    chk("rst_err", {31'd0, err_o[0]}, 32'd0);
    for (int k = 0; k < 3; k++) rst_q[k] = 1'b0;

    // Default instance: write/read, illegal request, rdata hold.
    do_txn(0, 1'b0, 1'b1, 9'd5, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
    do_txn(0, 1'b1, 1'b0, 9'd5, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
    do_txn(0, 1'b0, 1'b1, 9'd7, 32'h11112222, 4'hF, 32'hDEADBEEF, 1'b0);
    do_txn(0, 1'b1, 1'b1, 9'd7, 32'h99999999, 4'hF, 32'hDEADBEEF, 1'b1);
    do_txn(0, 1'b1, 1'b0, 9'd7, 32'h0,        4'hF, 32'h11112222, 1'b0);

    // Zero-wait instance: preload, then one read held across two transactions.
    do_txn(1, 1'b0, 1'b1, 9'd1, 32'hA1A1A1A1, 4'hF, 32'd0, 1'b0);
    do_txn(1, 1'b0, 1'b1, 9'd2, 32'hB2B2B2B2, 4'hF, 32'd0, 1'b0);
    e.err = 1'b0;
    e.rdata = 32'hA1A1A1A1; sb.push_back(e);
    e.rdata = 32'hB2B2B2B2; sb.push_back(e);
    @(negedge clk);
    rd_q[1] = 1'b1; addr_q[1] = 9'd1;
    n = 0; np = 0; t1 = -1; t2 = -1;
    while (np < 2 && n < 30) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (rdy_o[1]) begin
        e = sb.pop_front();
        chk("held_rdata", rdata_o[1], e.rdata);
        if (np == 0) t1 = n; else t2 = n;
        addr_q[1] = 9'd2;
        np++;
      end
    end
    rd_q[1] = 1'b0;
    chk("held_first_lat", 32'(t1), 32'd2);
    chk("held_gap", 32'(t2 - t1), 32'd3);

    // DEPTH=256 instance: out-of-range write/read must not alias onto 300 mod 256.
    do_txn(2, 1'b0, 1'b1, 9'd44,  32'h44440044, 4'hF, 32'd0, 1'b0);
    do_txn(2, 1'b0, 1'b1, 9'd300, 32'h00001234, 4'hF, 32'd0, 1'b1);
    do_txn(2, 1'b1, 1'b0, 9'd300, 32'h0,        4'hF, 32'd0, 1'b1);
    do_txn(2, 1'b1, 1'b0, 9'd44,  32'h0,        4'hF, 32'h44440044, 1'b0);

    // Reset during WAIT abandons the write.
    do_txn(0, 1'b0, 1'b1, 9'd9, 32'h0BADF00D, 4'hF, 32'h11112222, 1'b0);
    @(negedge clk);
    wr_q[0] = 1'b1; addr_q[0] = 9'd9; wd_q[0] = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    chk("wait_busy", {31'd0, busy_o[0]}, 32'd1);
    rst_q[0] = 1'b1; wr_q[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstw_busy", {31'd0, busy_o[0]}, 32'd0);
    chk("rstw_ready", {31'd0, rdy_o[0]}, 32'd0);
    chk("rstw_rdata", rdata_o[0], 32'd0);
    chk("rstw_err", {31'd0, err_o[0]}, 32'd0);
    rst_q[0] = 1'b0;
    do_txn(0, 1'b1, 1'b0, 9'd9, 32'h0, 4'hF, 32'h0BADF00D, 1'b0);

`ifdef MEM_RESP_BYTE_EN_EN
    do_txn(0, 1'b0, 1'b1, 9'd12, 32'hFFFFFFFF, 4'hF,    32'h0BADF00D, 1'b0);
    do_txn(0, 1'b0, 1'b1, 9'd12, 32'h00000000, 4'b0101, 32'h0BADF00D, 1'b0);
    do_txn(0, 1'b1, 1'b0, 9'd12, 32'h0,        4'hF,    32'hFF00FF00, 1'b0);
    do_txn(0, 1'b0, 1'b1, 9'd12, 32'h12345678, 4'b0000, 32'hFF00FF00, 1'b0);
    do_txn(0, 1'b1, 1'b0, 9'd12, 32'h0,        4'hF,    32'hFF00FF00, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder that services read and write requests from the multi-cycle core's memory port (read strobe, write strobe, word address, write data). It serves the initiator side with a level-request / one-cycle-`ready` handshake and a programmable number of wait states. Slow or shared memories can then replace the zero-latency shared instruction/data memory without changing the core's datapath. It sits between the core's memory-address/write-data muxes and the instruction/data registers, clocked on the same stepped clock as the core.

## Interface
- `ADDR_W`, 9, word-address width (the core drives byte address bits [10:2]).
- `DEPTH`, 512, number of 32-bit words implemented; must be ≤ 2^`ADDR_W`.
- `WAIT_CYCLES`, 2, wait-state cycles inserted before each access; 0..15.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  read request, level; held until `ready`.
- `mem_write`  in  1  write request, level; held until `ready`.
- `addr`  in  `ADDR_W`  word address.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; registered, held until the next completed read.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  valid with `ready`: illegal request or out-of-range address.

## Operation
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - `mem_read` or `mem_write` high at an edge → latch `addr`, `wdata` and op.
  - Next state is WAIT with counter = `WAIT_CYCLES`, or ACCESS if `WAIT_CYCLES` = 0.
- WAIT: counter decrements each cycle; when counter = 1 at an edge → ACCESS.
- ACCESS:
  - Write: store latched `wdata` at the latched address at the edge ending ACCESS.
  - Read: load `rdata` from the array at that edge.
  - Always → DONE.
- DONE: `ready` = 1 for exactly this cycle; `err` valid; → IDLE unconditionally.
- Requests are ignored outside IDLE. Address, data and op changes after the latch edge have no effect.
- `mem_read` and `mem_write` both high at the latch edge is illegal:
  - No array access, `rdata` unchanged.
  - Completes normally with `err` = 1.
- Latched address ≥ `DEPTH`:
  - Write is dropped.
  - Read loads `rdata` = 0.
  - `err` = 1.
- Array contents are not cleared by reset.

## Timing
- Reset values: state IDLE, `rdata` = 0, `ready` = 0, `busy` = 0, `err` = 0, counter = 0.
- Latency: `ready` high during the (`WAIT_CYCLES` + 2)-th cycle after the latching edge. Default: 4 cycles. `WAIT_CYCLES` = 0: 2 cycles.
- Back-to-back requests:
  - A request still high in the IDLE cycle after DONE starts a new transaction.
  - The initiator must drop its request at the edge where it observes `ready`.
  - Minimum spacing is `WAIT_CYCLES` + 3 cycles per transaction.
- Write-then-read to the same address returns the new data.
- `rst` in WAIT: write is abandoned and the array is unchanged.
- `rst` in ACCESS: reset wins, so the write is not performed and `rdata` is reset to 0.
- `busy` rises the cycle after the latch edge and falls the cycle after DONE.

## Configuration
- Macro `MEM_RESP_BYTE_EN_EN`.
- Defined:
  - Adds input `be` [3:0].
  - Writes update only the byte lanes whose `be` bit is 1; `be[0]` maps to `wdata[7:0]`.
  - `be` is latched with `wdata`.
  - `be` = 0000 is a legal no-op write with `err` = 0.
  - Reads ignore `be`.
- Undefined: no `be` port; every write updates all 32 bits.

## Test plan
- Reset, default params: write `addr` = 5, `wdata` = 32'hDEADBEEF → `ready` in cycle 4, `err` = 0. Then read `addr` = 5 → `rdata` = 32'hDEADBEEF in the `ready` cycle; `busy` high for exactly 4 cycles per transaction.
- `WAIT_CYCLES` = 0: read held continuously for two transactions to addresses 1 and 2 → `ready` pulses 3 cycles apart, each 1 cycle wide.
- `mem_read` = `mem_write` = 1, `addr` = 7 → `err` = 1 with `ready`. Subsequent read of 7 returns its prior value; `rdata` is unchanged by the illegal transaction.
- `DEPTH` = 256, write 32'h1234 to `addr` = 300 → `err` = 1. Read 300 → `rdata` = 0, `err` = 1. Read 44 (300 mod 256) → unchanged.
- Write 32'hAAAA5555 to `addr` 9, assert `rst` during WAIT → outputs return to reset values next cycle. Read 9 → old contents.
- With `MEM_RESP_BYTE_EN_EN`: write 32'hFFFFFFFF, then write 32'h00000000 with `be` = 4'b0101 → read returns 32'hFF00FF00.
